// File: rtl/demux14_pkg.sv
// demux14_pkg
// Shared constants and types for the 1-to-4 stream demultiplexer.
//   NUM_LANES  : number of output lanes
//   SEL_W      : width of a lane index
//   lane_idx_t : lane index type used for in_sel, rr_ptr and dest
package demux14_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  typedef logic [SEL_W-1:0] lane_idx_t;

endpackage : demux14_pkg

// File: rtl/demux14_lane_fifo.sv
// demux14_lane_fifo
// Synchronous FIFO buffering the beats of one output lane. There is no
// fall-through, so a pushed beat becomes visible on the cycle after the push.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write wr_data_i this edge (ignored when full)
//   wr_data_i  : payload to write
//   full_o     : registered full flag
//   pop_i      : discard the head this edge (ignored when empty)
//   rd_data_o  : head entry (register-addressed storage read)
//   empty_o    : registered empty flag
module demux14_lane_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // The extra MSB on each pointer tells a full FIFO (same index, lap bit
  // differs) from an empty one (pointers identical).
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state: each pointer advances independently.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Storage is cleared on reset so the head reads zero while the lane is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule : demux14_lane_fifo

// File: rtl/demux14.sv
// demux14
// 1-to-4 valid/ready stream demultiplexer with per-lane FIFO buffering.
// Beats go to lane in_sel, or to the round-robin pointer when rr_mode=1.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake, in_data payload
//   in_sel, rr_mode      : explicit lane select / round-robin enable
//   rr_ptr               : current round-robin destination
//   out_valid/out_ready  : per-lane handshakes
//   out_data             : lane i payload at [i*WIDTH +: WIDTH]
module demux14
  import demux14_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  lane_idx_t                  in_sel,
  input  logic                       rr_mode,
  output lane_idx_t                  rr_ptr,
  output logic [NUM_LANES-1:0]       out_valid,
  input  logic [NUM_LANES-1:0]       out_ready,
  output logic [NUM_LANES*WIDTH-1:0] out_data
);

  lane_idx_t            dest;
  lane_idx_t            rr_ptr_q, rr_ptr_d;
  logic [NUM_LANES-1:0] lane_full, lane_empty, lane_push, lane_pop;
  logic                 accept;

  // in_ready only looks at the registered full flag of the chosen lane, so a
  // full lane never accepts even when it pops in the same cycle.
  assign dest     = rr_mode ? rr_ptr_q : in_sel;
  assign in_ready = rst_n && !lane_full[dest];
  assign accept   = in_valid && in_ready;
  assign rr_ptr   = rr_ptr_q;

  assign out_valid = ~lane_empty;
  assign lane_pop  = out_valid & out_ready;

  // One-hot push decode towards the destination lane.
  always_comb begin
    lane_push = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_push[i] = accept && (dest == lane_idx_t'(i));
    end
  end

  // The pointer only moves on beats actually routed round-robin; the 2-bit
  // add wraps 3 -> 0 on its own.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && rr_mode) rr_ptr_d = rr_ptr_q + lane_idx_t'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    demux14_lane_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_i   (lane_push[gi]),
      .wr_data_i(in_data),
      .full_o   (lane_full[gi]),
      .pop_i    (lane_pop[gi]),
      .rd_data_o(out_data[gi*WIDTH +: WIDTH]),
      .empty_o  (lane_empty[gi])
    );
  end

endmodule : demux14

// File: tb/tb_demux14.sv
// tb_demux14
// Self-checking bench for demux14 (WIDTH=8, DEPTH=2): a table of directed
// vectors, hand-written reset sequences, then randomized traffic compared
// against a queue-based reference model.
module tb_demux14;

  localparam int W = 8;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic         rr_mode;
  logic [1:0]   rr_ptr;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [4*W-1:0] out_data;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic       valid;
    logic [1:0] sel;
    logic       rrMode;
    logic [7:0] data;
    logic [3:0] outReady;
    logic       expInReady;
    logic [3:0] expOutValid;
    logic [1:0] expRrPtr;
    logic [1:0] chkLane;
    logic [7:0] expData;
  } vec_t;

  vec_t vecs[$];

  // Reference model: one queue per lane plus a round-robin counter.
  logic [7:0] modelQ[4][$];
  int         modelRr;

  demux14 #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .rr_mode  (rr_mode),
    .rr_ptr   (rr_ptr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  // Drives one cycle's worth of inputs.
  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic rr,
                               input logic [7:0] d, input logic [3:0] ordy);
    in_valid  = v;
    in_sel    = s;
    rr_mode   = rr;
    in_data   = d;
    out_ready = ordy;
  endtask

  // Single comparison with failure reporting.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void addVec(logic v, logic [1:0] s, logic rr, logic [7:0] d,
                                 logic [3:0] ordy, logic eir, logic [3:0] eov,
                                 logic [1:0] err, logic [1:0] cl, logic [7:0] ed);
    vec_t x;
    x.valid = v; x.sel = s; x.rrMode = rr; x.data = d; x.outReady = ordy;
    x.expInReady = eir; x.expOutValid = eov; x.expRrPtr = err;
    x.chkLane = cl; x.expData = ed;
    vecs.push_back(x);
  endfunction

  initial begin
    // Directed table: expected values are what is seen just before the edge.
    //     v  sel rr data   ordy     ir ov       rr  lane data
    // select routing
    addVec(1, 2, 0, 8'hA1, 4'b1111, 1, 4'b0000, 0, 0, 8'h00);
    addVec(1, 0, 0, 8'hB2, 4'b1111, 1, 4'b0100, 0, 2, 8'hA1);
    addVec(1, 2, 0, 8'hC3, 4'b1111, 1, 4'b0001, 0, 0, 8'hB2);
    addVec(0, 0, 0, 8'h00, 4'b1111, 1, 4'b0100, 0, 2, 8'hC3);
    addVec(0, 0, 0, 8'h00, 4'b1111, 1, 4'b0000, 0, 0, 8'h00);
    // round-robin wrap
    addVec(1, 0, 1, 8'h10, 4'b1111, 1, 4'b0000, 0, 0, 8'h00);
    addVec(1, 0, 1, 8'h11, 4'b1111, 1, 4'b0001, 1, 0, 8'h10);
    addVec(1, 0, 1, 8'h12, 4'b1111, 1, 4'b0010, 2, 1, 8'h11);
    addVec(1, 0, 1, 8'h13, 4'b1111, 1, 4'b0100, 3, 2, 8'h12);
    addVec(1, 0, 1, 8'h14, 4'b1111, 1, 4'b1000, 0, 3, 8'h13);
    addVec(0, 0, 0, 8'h00, 4'b1111, 1, 4'b0001, 1, 0, 8'h14);
    // full / backpressure on lane 1
    addVec(1, 1, 0, 8'h21, 4'b1101, 1, 4'b0000, 1, 1, 8'h00);
    addVec(1, 1, 0, 8'h22, 4'b1101, 1, 4'b0010, 1, 1, 8'h21);
    addVec(1, 1, 0, 8'h23, 4'b1101, 0, 4'b0010, 1, 1, 8'h21);
    addVec(1, 1, 0, 8'h23, 4'b1111, 0, 4'b0010, 1, 1, 8'h21);
    addVec(1, 1, 0, 8'h23, 4'b1101, 1, 4'b0010, 1, 1, 8'h22);
    // independence: lane 3 streams while lane 1 is full and stalled
    addVec(1, 3, 0, 8'h31, 4'b1101, 1, 4'b0010, 1, 1, 8'h22);
    addVec(1, 3, 0, 8'h32, 4'b1101, 1, 4'b1010, 1, 3, 8'h31);
    addVec(1, 3, 0, 8'h33, 4'b1101, 1, 4'b1010, 1, 3, 8'h32);
    addVec(0, 3, 0, 8'h00, 4'b1101, 1, 4'b1010, 1, 3, 8'h33);
    addVec(0, 1, 0, 8'h00, 4'b1101, 0, 4'b0010, 1, 1, 8'h22);
    // load lane 0 as well before the mid-operation reset
    addVec(1, 0, 0, 8'h41, 4'b0000, 1, 4'b0010, 1, 1, 8'h22);

    // Reset asserted with a beat offered.
    rst_n = 1'b0;
    applyStimulus(1, 0, 0, 8'h55, 4'b1111);
    repeat (2) @(negedge clk);
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset rr_ptr", 32'(rr_ptr), 32'd0);
    checkOutput("reset out_data", out_data, 32'd0);
    applyStimulus(0, 0, 0, 8'h00, 4'b1111);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].valid, vecs[k].sel, vecs[k].rrMode, vecs[k].data,
                    vecs[k].outReady);
      @(negedge clk);
      checkOutput($sformatf("vec%0d in_ready", k), 32'(in_ready), 32'(vecs[k].expInReady));
      checkOutput($sformatf("vec%0d out_valid", k), 32'(out_valid), 32'(vecs[k].expOutValid));
      checkOutput($sformatf("vec%0d rr_ptr", k), 32'(rr_ptr), 32'(vecs[k].expRrPtr));
      if (vecs[k].expOutValid[vecs[k].chkLane])
        checkOutput($sformatf("vec%0d lane%0d data", k, vecs[k].chkLane),
                    32'(out_data[vecs[k].chkLane*W +: W]), 32'(vecs[k].expData));
      @(posedge clk); #1;
    end

    // Mid-operation reset: lanes 0 and 1 hold beats; pulse reset between edges.
    applyStimulus(0, 0, 0, 8'h00, 4'b0000);
    checkOutput("pre-reset out_valid", 32'(out_valid), 32'b0011);
    checkOutput("pre-reset lane0 data", 32'(out_data[0 +: W]), 32'h41);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("async reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("async reset rr_ptr", 32'(rr_ptr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput($sformatf("after reset c%0d out_valid", c), 32'(out_valid), 32'd0);
      checkOutput($sformatf("after reset c%0d in_ready", c), 32'(in_ready), 32'd1);
    end
    @(posedge clk); #1;

    // Randomized traffic against the model. A stalled beat is held unchanged.
    begin
      logic       curValid, curRr, hold, accept;
      logic [1:0] curSel;
      logic [7:0] curData;
      logic [3:0] curReady, pops;
      int         dest;
      modelRr = 0;
      for (int i = 0; i < 4; i++) modelQ[i].delete();
      hold = 1'b0;
      curValid = 1'b0; curRr = 1'b0; curSel = '0; curData = '0;
      for (int c = 0; c < 1500; c++) begin
        if (!hold) begin
          curValid = ($urandom_range(0, 3) != 0);
          curSel   = 2'($urandom_range(0, 3));
          curRr    = 1'($urandom_range(0, 1));
          curData  = 8'($urandom);
        end
        for (int i = 0; i < 4; i++) curReady[i] = ($urandom_range(0, 2) != 0);
        applyStimulus(curValid, curSel, curRr, curData, curReady);
        @(negedge clk);
        dest = curRr ? modelRr : int'(curSel);
        checkOutput("rand in_ready", 32'(in_ready), 32'(modelQ[dest].size() < D));
        checkOutput("rand rr_ptr", 32'(rr_ptr), 32'(modelRr));
        for (int i = 0; i < 4; i++) begin
          checkOutput($sformatf("rand out_valid[%0d]", i), 32'(out_valid[i]),
                      32'(modelQ[i].size() != 0));
          if (modelQ[i].size() != 0)
            checkOutput($sformatf("rand lane%0d data", i), 32'(out_data[i*W +: W]),
                        32'(modelQ[i][0]));
        end
        accept = curValid && (modelQ[dest].size() < D);
        for (int i = 0; i < 4; i++) pops[i] = curReady[i] && (modelQ[i].size() != 0);
        hold = curValid && !accept;
        @(posedge clk);
        for (int i = 0; i < 4; i++) if (pops[i]) void'(modelQ[i].pop_front());
        if (accept) begin
          modelQ[dest].push_back(curData);
          if (curRr) modelRr = (modelRr + 1) % 4;
        end
        #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule : tb_demux14
